// File: rtl/mips_run_ctrl.sv
// Purpose  : run controller for a MIPS core; sequences core reset, counts cycles and
//            retired instructions, and stops the core on a PC self-loop, halt PC or timeout.
// Latency  : every output is registered and reflects the inputs of the previous edge.
// Backpress: none; start is honoured only in IDLE/DONE/TIMEOUT and ignored otherwise.
//
// Ports
//   clk        core clock, all state on rising edge
//   reset      asynchronous active-high, returns everything to IDLE immediately
//   start      one-cycle request to (re)start the core
//   pc_valid   core retired an instruction this cycle
//   pc         PC of the retired instruction (qualified by pc_valid)
//   cpu_reset  reset to the core; low only while running
//   running    high only while the core is free-running
//   done       sticky, halt detected
//   timeout    sticky, MAX_CYCLES elapsed without a halt
//   cycle_cnt  RUN cycles elapsed (saturating)
//   instr_cnt  instructions retired during RUN (saturating)
module mips_run_ctrl #(
  parameter int              PC_W        = 32,
  parameter int              CNT_W       = 32,
  parameter int              RST_CYCLES  = 4,
  parameter int              HALT_STABLE = 3,
  parameter logic [PC_W-1:0] HALT_PC     = '0,
  parameter int              MAX_CYCLES  = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pc_valid,
  input  logic [PC_W-1:0]  pc,
  output logic             cpu_reset,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int RP_W = (HALT_STABLE > 1) ? $clog2(HALT_STABLE) : 1;

  localparam logic [RC_W-1:0]  RST_LAST = RC_W'(RST_CYCLES - 1);
  localparam logic [RP_W-1:0]  REP_LAST = RP_W'(HALT_STABLE - 1);
  localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(MAX_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST_HOLD,
    ST_RUN,
    ST_DONE,
    ST_TIMEOUT
  } state_t;

  state_t           state, state_n;
  logic [RC_W-1:0]  rst_cnt, rst_cnt_n;
  logic [RP_W-1:0]  rep_cnt, rep_cnt_n;
  logic [PC_W-1:0]  last_pc, last_pc_n;
  logic [CNT_W-1:0] cycle_cnt_n, instr_cnt_n;
  logic             done_n, timeout_n;
  logic             cpu_reset_n, running_n;

  logic             pc_match;
  logic             halt;

  // Repeat detection runs on the live inputs so the halting instruction is the
  // one that closes the loop, not the one after it.
  assign pc_match = pc_valid && (pc == last_pc);
  assign halt     = (pc_match && (rep_cnt == REP_LAST)) ||
                    ((HALT_PC != '0) && pc_valid && (pc == HALT_PC));

  always_comb begin
    state_n     = state;
    rst_cnt_n   = rst_cnt;
    rep_cnt_n   = rep_cnt;
    last_pc_n   = last_pc;
    cycle_cnt_n = cycle_cnt;
    instr_cnt_n = instr_cnt;
    done_n      = done;
    timeout_n   = timeout;

    case (state)
      ST_IDLE, ST_DONE, ST_TIMEOUT: begin
        // A restart wipes the previous run's results on the same edge, so the
        // first PC of the new run compares against 0.
        if (start) begin
          state_n     = ST_RST_HOLD;
          rst_cnt_n   = '0;
          rep_cnt_n   = '0;
          last_pc_n   = '0;
          cycle_cnt_n = '0;
          instr_cnt_n = '0;
          done_n      = 1'b0;
          timeout_n   = 1'b0;
        end
      end

      ST_RST_HOLD: begin
        if (rst_cnt == RST_LAST) begin
          state_n = ST_RUN;
        end else begin
          rst_cnt_n = rst_cnt + RC_W'(1);
        end
      end

      ST_RUN: begin
        if (!(&cycle_cnt)) begin
          cycle_cnt_n = cycle_cnt + CNT_W'(1);
        end
        if (pc_valid) begin
          if (!(&instr_cnt)) begin
            instr_cnt_n = instr_cnt + CNT_W'(1);
          end
          if (pc_match) begin
            // Stop counting once the threshold is reached; the halt leaves RUN anyway.
            if (rep_cnt != REP_LAST) begin
              rep_cnt_n = rep_cnt + RP_W'(1);
            end
          end else begin
            rep_cnt_n = '0;
            last_pc_n = pc;
          end
        end
        // Halt takes priority when it lands on the final allowed cycle.
        if (halt) begin
          state_n = ST_DONE;
          done_n  = 1'b1;
        end else if (cycle_cnt == CYC_LAST) begin
          state_n   = ST_TIMEOUT;
          timeout_n = 1'b1;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase

    // Core-facing controls are derived from the next state so they change on
    // the same edge as the state itself.
    running_n   = (state_n == ST_RUN);
    cpu_reset_n = (state_n != ST_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      rst_cnt   <= '0;
      rep_cnt   <= '0;
      last_pc   <= '0;
      cycle_cnt <= '0;
      instr_cnt <= '0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      cpu_reset <= 1'b1;
      running   <= 1'b0;
    end else begin
      state     <= state_n;
      rst_cnt   <= rst_cnt_n;
      rep_cnt   <= rep_cnt_n;
      last_pc   <= last_pc_n;
      cycle_cnt <= cycle_cnt_n;
      instr_cnt <= instr_cnt_n;
      done      <= done_n;
      timeout   <= timeout_n;
      cpu_reset <= cpu_reset_n;
      running   <= running_n;
    end
  end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed bench for mips_run_ctrl: reset, start sequencing, self-loop halt,
// halt-PC, timeout, halt on the last allowed cycle, mid-run reset and restart.
module tb_mips_run_ctrl;

  localparam int              PC_W        = 32;
  localparam int              CNT_W       = 32;
  localparam int              RST_CYCLES  = 4;
  localparam int              HALT_STABLE = 3;
  localparam logic [31:0]     HALT_PC     = 32'h0000_3010;
  localparam int              MAX_CYCLES  = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             pc_valid;
  logic [PC_W-1:0]  pc;
  logic             cpu_reset;
  logic             running;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instr_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  mips_run_ctrl #(
    .PC_W       (PC_W),
    .CNT_W      (CNT_W),
    .RST_CYCLES (RST_CYCLES),
    .HALT_STABLE(HALT_STABLE),
    .HALT_PC    (HALT_PC),
    .MAX_CYCLES (MAX_CYCLES)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .pc_valid (pc_valid),
    .pc       (pc),
    .cpu_reset(cpu_reset),
    .running  (running),
    .done     (done),
    .timeout  (timeout),
    .cycle_cnt(cycle_cnt),
    .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are read 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one input cycle and let the next edge sample it.
  task automatic drive(input logic v, input logic [31:0] p);
    pc_valid = v;
    pc       = p;
    tick();
  endtask

  // Pulse start and wait out the reset hold; running is expected afterwards.
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (RST_CYCLES) tick();
    n_chk++; if (running !== 1'b1) $display("FAIL start_running got %0b exp 1", running); else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; pc_valid = 1'b0; pc = '0;
    repeat (3) tick();
    n_chk++; if (cpu_reset !== 1'b1) $display("FAIL rst_cpu_reset got %0b exp 1", cpu_reset); else n_pass++;
    n_chk++; if (running !== 1'b0)   $display("FAIL rst_running got %0b exp 0", running); else n_pass++;
    n_chk++; if (done !== 1'b0)      $display("FAIL rst_done got %0b exp 0", done); else n_pass++;
    n_chk++; if (timeout !== 1'b0)   $display("FAIL rst_timeout got %0b exp 0", timeout); else n_pass++;
    n_chk++; if (cycle_cnt !== 32'd0) $display("FAIL rst_cycle_cnt got %0d exp 0", cycle_cnt); else n_pass++;
    n_chk++; if (instr_cnt !== 32'd0) $display("FAIL rst_instr_cnt got %0d exp 0", instr_cnt); else n_pass++;
    reset = 1'b0;
    tick();
    n_chk++; if (cpu_reset !== 1'b1 || running !== 1'b0) $display("FAIL idle_hold got cpu_reset=%0b running=%0b exp 1/0", cpu_reset, running); else n_pass++;
  endtask

  // T1: cpu_reset held for exactly RST_CYCLES cycles after the edge sampling start.
  task automatic test_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < RST_CYCLES - 1; i++) begin
      tick();
      n_chk++; if (cpu_reset !== 1'b1 || running !== 1'b0) $display("FAIL t1_hold%0d got cpu_reset=%0b running=%0b exp 1/0", i, cpu_reset, running); else n_pass++;
    end
    tick();
    n_chk++; if (cpu_reset !== 1'b0 || running !== 1'b1) $display("FAIL t1_run got cpu_reset=%0b running=%0b exp 0/1", cpu_reset, running); else n_pass++;
    n_chk++; if (cycle_cnt !== 32'd0) $display("FAIL t1_cycle_cnt got %0d exp 0", cycle_cnt); else n_pass++;
  endtask

  // T2: self-loop; halt on the 4th consecutive 0x3008.
  task automatic test_self_loop();
    logic [31:0] pcs [6];
    pcs = '{32'h3000, 32'h3004, 32'h3008, 32'h3008, 32'h3008, 32'h3008};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, pcs[i]);
      if (i == 4) begin
        n_chk++; if (done !== 1'b0 || running !== 1'b1) $display("FAIL t2_early got done=%0b running=%0b exp 0/1", done, running); else n_pass++;
      end
    end
    n_chk++; if (done !== 1'b1)        $display("FAIL t2_done got %0b exp 1", done); else n_pass++;
    n_chk++; if (timeout !== 1'b0)     $display("FAIL t2_timeout got %0b exp 0", timeout); else n_pass++;
    n_chk++; if (instr_cnt !== 32'd6)  $display("FAIL t2_instr_cnt got %0d exp 6", instr_cnt); else n_pass++;
    n_chk++; if (cycle_cnt !== 32'd6)  $display("FAIL t2_cycle_cnt got %0d exp 6", cycle_cnt); else n_pass++;
    n_chk++; if (cpu_reset !== 1'b1 || running !== 1'b0) $display("FAIL t2_frozen got cpu_reset=%0b running=%0b exp 1/0", cpu_reset, running); else n_pass++;
  endtask

  // T3: explicit halt address; later PCs must not move the counters.
  task automatic test_halt_pc();
    do_start();
    n_chk++; if (done !== 1'b0 || instr_cnt !== 32'd0 || cycle_cnt !== 32'd0) $display("FAIL t3_cleared got done=%0b instr=%0d cyc=%0d exp 0/0/0", done, instr_cnt, cycle_cnt); else n_pass++;
    for (int i = 0; i < 5; i++) drive(1'b1, 32'h3000 + 32'(4 * i));
    n_chk++; if (done !== 1'b1)       $display("FAIL t3_done got %0b exp 1", done); else n_pass++;
    n_chk++; if (instr_cnt !== 32'd5) $display("FAIL t3_instr_cnt got %0d exp 5", instr_cnt); else n_pass++;
    for (int i = 5; i < 10; i++) drive(1'b1, 32'h3000 + 32'(4 * i));
    n_chk++; if (instr_cnt !== 32'd5 || cycle_cnt !== 32'd5) $display("FAIL t3_frozen got instr=%0d cyc=%0d exp 5/5", instr_cnt, cycle_cnt); else n_pass++;
    n_chk++; if (done !== 1'b1 || cpu_reset !== 1'b1) $display("FAIL t3_sticky got done=%0b cpu_reset=%0b exp 1/1", done, cpu_reset); else n_pass++;
  endtask

  // T4: PCs never repeat; timeout after MAX_CYCLES RUN cycles, then held.
  task automatic test_timeout();
    do_start();
    for (int i = 0; i < MAX_CYCLES - 1; i++) drive(1'b1, 32'h4000 + 32'(4 * i));
    n_chk++; if (timeout !== 1'b0 || cycle_cnt !== 32'd15 || running !== 1'b1) $display("FAIL t4_pre got timeout=%0b cyc=%0d running=%0b exp 0/15/1", timeout, cycle_cnt, running); else n_pass++;
    drive(1'b1, 32'h4000 + 32'(4 * (MAX_CYCLES - 1)));
    n_chk++; if (timeout !== 1'b1)     $display("FAIL t4_timeout got %0b exp 1", timeout); else n_pass++;
    n_chk++; if (done !== 1'b0)        $display("FAIL t4_done got %0b exp 0", done); else n_pass++;
    n_chk++; if (cycle_cnt !== 32'd16) $display("FAIL t4_cycle_cnt got %0d exp 16", cycle_cnt); else n_pass++;
    n_chk++; if (instr_cnt !== 32'd16) $display("FAIL t4_instr_cnt got %0d exp 16", instr_cnt); else n_pass++;
    n_chk++; if (cpu_reset !== 1'b1 || running !== 1'b0) $display("FAIL t4_core got cpu_reset=%0b running=%0b exp 1/0", cpu_reset, running); else n_pass++;
    for (int i = 0; i < 20; i++) drive(1'b1, 32'h4100 + 32'(4 * i));
    n_chk++; if (timeout !== 1'b1 || cycle_cnt !== 32'd16 || instr_cnt !== 32'd16 || cpu_reset !== 1'b1) $display("FAIL t4_held got timeout=%0b cyc=%0d instr=%0d cpu_reset=%0b exp 1/16/16/1", timeout, cycle_cnt, instr_cnt, cpu_reset); else n_pass++;
  endtask

  // T5: self-loop closes on the final allowed cycle; halt beats timeout.
  task automatic test_halt_at_limit();
    do_start();
    repeat (12) drive(1'b0, 32'h0);
    repeat (4)  drive(1'b1, 32'h5000);
    n_chk++; if (done !== 1'b1)        $display("FAIL t5_done got %0b exp 1", done); else n_pass++;
    n_chk++; if (timeout !== 1'b0)     $display("FAIL t5_timeout got %0b exp 0", timeout); else n_pass++;
    n_chk++; if (cycle_cnt !== 32'd16) $display("FAIL t5_cycle_cnt got %0d exp 16", cycle_cnt); else n_pass++;
    n_chk++; if (instr_cnt !== 32'd4)  $display("FAIL t5_instr_cnt got %0d exp 4", instr_cnt); else n_pass++;
  endtask

  // T6a: start ignored in RUN, then asynchronous reset between edges.
  task automatic test_reset_midrun();
    do_start();
    for (int i = 0; i < 7; i++) begin
      start = (i == 3);
      drive(1'b1, 32'h6000 + 32'(4 * i));
    end
    start = 1'b0;
    n_chk++; if (cycle_cnt !== 32'd7 || instr_cnt !== 32'd7 || running !== 1'b1) $display("FAIL t6_midrun got cyc=%0d instr=%0d running=%0b exp 7/7/1", cycle_cnt, instr_cnt, running); else n_pass++;
    #2;
    reset = 1'b1;
    #1;
    n_chk++; if (cpu_reset !== 1'b1 || running !== 1'b0) $display("FAIL t6_async_core got cpu_reset=%0b running=%0b exp 1/0", cpu_reset, running); else n_pass++;
    n_chk++; if (cycle_cnt !== 32'd0 || instr_cnt !== 32'd0) $display("FAIL t6_async_cnt got cyc=%0d instr=%0d exp 0/0", cycle_cnt, instr_cnt); else n_pass++;
    #1;
    reset = 1'b0;
    tick();
    n_chk++; if (cpu_reset !== 1'b1 || running !== 1'b0) $display("FAIL t6_idle got cpu_reset=%0b running=%0b exp 1/0", cpu_reset, running); else n_pass++;
  endtask

  // T6b: halt with a bubble inside the loop, restart from DONE with a full
  // reset hold (start re-pulsed mid-hold must not extend it), then pc==0 loop.
  task automatic test_back_to_back();
    logic        v   [7];
    logic [31:0] pcs [7];
    v   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    pcs = '{32'h3000, 32'h3004, 32'h3008, 32'h0, 32'h3008, 32'h3008, 32'h3008};
    do_start();
    for (int i = 0; i < 7; i++) drive(v[i], pcs[i]);
    n_chk++; if (done !== 1'b1 || instr_cnt !== 32'd6 || cycle_cnt !== 32'd7) $display("FAIL b2b_bubble got done=%0b instr=%0d cyc=%0d exp 1/6/7", done, instr_cnt, cycle_cnt); else n_pass++;
    pc_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_chk++; if (done !== 1'b0 || cycle_cnt !== 32'd0 || instr_cnt !== 32'd0) $display("FAIL b2b_clear got done=%0b cyc=%0d instr=%0d exp 0/0/0", done, cycle_cnt, instr_cnt); else n_pass++;
    n_chk++; if (cpu_reset !== 1'b1) $display("FAIL b2b_hold0 got %0b exp 1", cpu_reset); else n_pass++;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_chk++; if (running !== 1'b0) $display("FAIL b2b_hold2 got %0b exp 0", running); else n_pass++;
    tick();
    n_chk++; if (running !== 1'b0 || cpu_reset !== 1'b1) $display("FAIL b2b_hold3 got running=%0b cpu_reset=%0b exp 0/1", running, cpu_reset); else n_pass++;
    tick();
    n_chk++; if (running !== 1'b1 || cpu_reset !== 1'b0) $display("FAIL b2b_run got running=%0b cpu_reset=%0b exp 1/0", running, cpu_reset); else n_pass++;
    repeat (2) drive(1'b1, 32'h0);
    n_chk++; if (done !== 1'b0) $display("FAIL pc0_early got %0b exp 0", done); else n_pass++;
    drive(1'b1, 32'h0);
    n_chk++; if (done !== 1'b1 || instr_cnt !== 32'd3 || cycle_cnt !== 32'd3) $display("FAIL pc0_done got done=%0b instr=%0d cyc=%0d exp 1/3/3", done, instr_cnt, cycle_cnt); else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got no finish exp finish before 100000");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_start();
    test_self_loop();
    test_halt_pc();
    test_timeout();
    test_halt_at_limit();
    test_reset_midrun();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
